egress_meta_buffer: RTL and testbench

Per-port metadata buffer on the egress side of the CPU control interface. Egress pushes 31-bit metadata words into four independent FIFOs, and the head of each FIFO is presented to the software-facing interface as `interface_in_0..3`. Each `interface_out_ack[n]` pulse from the interface pops port n's head, so software polling consumes one word per read. The block sits between the egress ports and the CPU interface, and is the producer/acknowledge end of the `interface_in`/`interface_out_ack` handshake.

---
 rtl/egress_meta_pkg.sv | 13 +
 rtl/meta_fifo.sv | 59 +++++
 rtl/egress_meta_buffer.sv | 78 +++++++
 tb/tb_egress_meta_buffer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/egress_meta_pkg.sv
// Shared types and constants for the egress metadata buffer.
package egress_meta_pkg;
  localparam int META_W = 31;
  localparam int NUM_PORTS = 4;
  localparam logic [31:0] META_EMPTY_WORD = 32'h0;

  typedef logic [META_W-1:0] meta_t;

  // Software sees bit 31 as "valid"; an empty FIFO reads as all zeros.
  function automatic logic [31:0] pack_word(input logic valid, input meta_t head);
    return valid ? {1'b1, head} : META_EMPTY_WORD;
  endfunction
endpackage

// File: rtl/meta_fifo.sv
// Single-port-pair metadata FIFO: push/data/pop in, head/nonempty/full/drop out.
module meta_fifo
  import egress_meta_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  meta_t data,
  input  logic  pop,
  output meta_t head,
  output logic  nonempty,
  output logic  full,
  output logic  drop
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  // Handshake: push and pop are single-cycle strobes with no back-pressure;
  // a push while full (and no pop) is dropped, a pop while empty is ignored.
  meta_t          mem [DEPTH];
  logic [AW-1:0]  rptr;
  logic [AW-1:0]  wptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_nxt;
  logic           pop_ok;
  logic           push_ok;

  always_comb begin
    pop_ok    = pop && (count != '0);
    push_ok   = push && ((count != CW'(DEPTH)) || pop_ok);
    drop      = push && !push_ok;
    count_nxt = count + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rptr     <= '0;
      wptr     <= '0;
      count    <= '0;
      nonempty <= 1'b0;
      full     <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop_ok)  rptr <= rptr + AW'(1);
      count    <= count_nxt;
      nonempty <= (count_nxt != '0);
      full     <= (count_nxt == CW'(DEPTH));
    end
  end

  // Storage is deliberately not cleared by reset; the nonempty flag hides it.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wptr] <= data;
  end

  assign head = mem[rptr];
endmodule

// File: rtl/egress_meta_buffer.sv
// Four independent per-port metadata FIFOs feeding the CPU interface.
// Optional per-port drop counters under EGRESS_META_DROP_CNT_EN.
module egress_meta_buffer
  import egress_meta_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  meta_push,
  input  logic [30:0] meta_data_0,
  input  logic [30:0] meta_data_1,
  input  logic [30:0] meta_data_2,
  input  logic [30:0] meta_data_3,
  input  logic [3:0]  interface_out_ack,
  output logic [31:0] interface_in_0,
  output logic [31:0] interface_in_1,
  output logic [31:0] interface_in_2,
  output logic [31:0] interface_in_3,
`ifdef EGRESS_META_DROP_CNT_EN
  output logic [15:0] meta_drop_cnt_0,
  output logic [15:0] meta_drop_cnt_1,
  output logic [15:0] meta_drop_cnt_2,
  output logic [15:0] meta_drop_cnt_3,
`endif
  output logic [3:0]  meta_full
);
  meta_t                data_arr [NUM_PORTS];
  meta_t                head_arr [NUM_PORTS];
  logic [NUM_PORTS-1:0] nonempty;
  logic [NUM_PORTS-1:0] drop;

  assign data_arr[0] = meta_data_0;
  assign data_arr[1] = meta_data_1;
  assign data_arr[2] = meta_data_2;
  assign data_arr[3] = meta_data_3;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    meta_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (meta_push[p]),
      .data     (data_arr[p]),
      .pop      (interface_out_ack[p]),
      .head     (head_arr[p]),
      .nonempty (nonempty[p]),
      .full     (meta_full[p]),
      .drop     (drop[p])
    );
  end

  assign interface_in_0 = pack_word(nonempty[0], head_arr[0]);
  assign interface_in_1 = pack_word(nonempty[1], head_arr[1]);
  assign interface_in_2 = pack_word(nonempty[2], head_arr[2]);
  assign interface_in_3 = pack_word(nonempty[3], head_arr[3]);

`ifdef EGRESS_META_DROP_CNT_EN
  logic [15:0] drop_cnt [NUM_PORTS];

  // Saturating: holds at all-ones until the next reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (reset)
        drop_cnt[i] <= '0;
      else if (drop[i] && (drop_cnt[i] != 16'hFFFF))
        drop_cnt[i] <= drop_cnt[i] + 16'd1;
    end
  end

  assign meta_drop_cnt_0 = drop_cnt[0];
  assign meta_drop_cnt_1 = drop_cnt[1];
  assign meta_drop_cnt_2 = drop_cnt[2];
  assign meta_drop_cnt_3 = drop_cnt[3];
`else
  logic unused_drop;
  assign unused_drop = ^drop;
`endif
endmodule

// File: tb/tb_egress_meta_buffer.sv
// Bench for egress_meta_buffer: directed steps plus random traffic against a queue model.
module tb_egress_meta_buffer;
  localparam int DEPTH = 8;
  localparam int NP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  meta_push;
  logic [30:0] meta_data [NP];
  logic [3:0]  interface_out_ack;
  logic [31:0] interface_in_0, interface_in_1, interface_in_2, interface_in_3;
  logic [3:0]  meta_full;
`ifdef EGRESS_META_DROP_CNT_EN
  logic [15:0] meta_drop_cnt_0, meta_drop_cnt_1, meta_drop_cnt_2, meta_drop_cnt_3;
`endif

  // clock / reset block
  always #5 clk = ~clk;

  egress_meta_buffer #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .meta_push         (meta_push),
    .meta_data_0       (meta_data[0]),
    .meta_data_1       (meta_data[1]),
    .meta_data_2       (meta_data[2]),
    .meta_data_3       (meta_data[3]),
    .interface_out_ack (interface_out_ack),
    .interface_in_0    (interface_in_0),
    .interface_in_1    (interface_in_1),
    .interface_in_2    (interface_in_2),
    .interface_in_3    (interface_in_3),
`ifdef EGRESS_META_DROP_CNT_EN
    .meta_drop_cnt_0   (meta_drop_cnt_0),
    .meta_drop_cnt_1   (meta_drop_cnt_1),
    .meta_drop_cnt_2   (meta_drop_cnt_2),
    .meta_drop_cnt_3   (meta_drop_cnt_3),
`endif
    .meta_full         (meta_full)
  );

  // stimulus variables
  logic        rst_v;
  logic [3:0]  push_v;
  logic [3:0]  ack_v;
  logic [30:0] d_v [NP];

  // reference model: one queue per port, plus drop tallies
  logic [30:0] exp_q [NP][$];
  int unsigned drop_m [NP];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  function automatic logic [31:0] dut_in(input int p);
    case (p)
      0:       return interface_in_0;
      1:       return interface_in_1;
      2:       return interface_in_2;
      default: return interface_in_3;
    endcase
  endfunction

  function automatic logic [31:0] exp_in(input int p);
    if (exp_q[p].size() == 0) return 32'h0;
    return {1'b1, exp_q[p][0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] full_e;
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("%s_in%0d", tag, p), dut_in(p), exp_in(p));
      full_e[p] = (exp_q[p].size() == DEPTH);
    end
    chk($sformatf("%s_full", tag), {28'h0, meta_full}, {28'h0, full_e});
  endtask

  // driver: apply one cycle of stimulus, advance the model, then check
  task automatic tick(input string tag);
    reset             = rst_v;
    meta_push         = push_v;
    interface_out_ack = ack_v;
    for (int p = 0; p < NP; p++) meta_data[p] = d_v[p];
    @(posedge clk);
    for (int p = 0; p < NP; p++) begin
      if (rst_v) begin
        exp_q[p].delete();
        drop_m[p] = 0;
      end else begin
        if (ack_v[p] && exp_q[p].size() > 0) void'(exp_q[p].pop_front());
        if (push_v[p]) begin
          if (exp_q[p].size() < DEPTH) exp_q[p].push_back(d_v[p]);
          else if (drop_m[p] < 65535) drop_m[p]++;
        end
      end
    end
    #1;
    rst_v = 1'b0; push_v = '0; ack_v = '0;
    reset = 1'b0; meta_push = '0; interface_out_ack = '0;
    check_all(tag);
  endtask

  initial begin
    rst_v = 1'b1; push_v = '0; ack_v = '0;
    for (int p = 0; p < NP; p++) begin d_v[p] = '0; drop_m[p] = 0; end
    reset = 1'b1; meta_push = '0; interface_out_ack = '0;
    for (int p = 0; p < NP; p++) meta_data[p] = '0;

    // reset, then idle with acks on empty FIFOs
    tick("rst0");
    rst_v = 1'b1; tick("rst1");
    chk("rst_full", {28'h0, meta_full}, 32'h0);
    ack_v = 4'hF; tick("ack_empty");
    chk("ack_empty_in0", interface_in_0, 32'h0);

    // port 0: two pushes, two pops
    push_v = 4'b0001; d_v[0] = 31'h1234; tick("p0_push1");
    chk("p0_first", interface_in_0, 32'h80001234);
    push_v = 4'b0001; d_v[0] = 31'h5678; tick("p0_push2");
    chk("p0_head_held", interface_in_0, 32'h80001234);
    ack_v = 4'b0001; tick("p0_ack1");
    chk("p0_second", interface_in_0, 32'h80005678);
    ack_v = 4'b0001; tick("p0_ack2");
    chk("p0_empty", interface_in_0, 32'h0);
    chk("p0_others", interface_in_1 | interface_in_2 | interface_in_3, 32'h0);

    // port 2: fill, overflow, drain
    for (int i = 1; i <= DEPTH; i++) begin
      push_v = 4'b0100; d_v[2] = 31'(i); tick("p2_fill");
    end
    chk("p2_full", {31'h0, meta_full[2]}, 32'h1);
    push_v = 4'b0100; d_v[2] = 31'h99; tick("p2_drop");
    chk("p2_full_after_drop", {31'h0, meta_full[2]}, 32'h1);
`ifdef EGRESS_META_DROP_CNT_EN
    chk("p2_drop_cnt", {16'h0, meta_drop_cnt_2}, 32'h1);
`endif
    for (int i = 1; i <= DEPTH; i++) begin
      chk("p2_order", interface_in_2, 32'h80000000 | 32'(i));
      ack_v = 4'b0100; tick("p2_drain");
    end
    chk("p2_drained", interface_in_2, 32'h0);

    // port 1: full with simultaneous push and ack
    for (int i = 1; i <= DEPTH; i++) begin
      push_v = 4'b0010; d_v[1] = 31'h100 + 31'(i); tick("p1_fill");
    end
    push_v = 4'b0010; ack_v = 4'b0010; d_v[1] = 31'h1AA; tick("p1_both");
    chk("p1_full_kept", {31'h0, meta_full[1]}, 32'h1);
    chk("p1_head_adv", interface_in_1, 32'h80000102);
    for (int i = 0; i < DEPTH - 1; i++) begin
      ack_v = 4'b0010; tick("p1_drain");
    end
    chk("p1_last", interface_in_1, 32'h800001AA);
    ack_v = 4'b0010; tick("p1_final");

    // port 3: empty with simultaneous push and ack
    push_v = 4'b1000; ack_v = 4'b1000; d_v[3] = 31'h3C3C; tick("p3_both");
    chk("p3_retained", interface_in_3, 32'h80003C3C);
    ack_v = 4'b1000; tick("p3_clear");

    // reset mid-operation with a colliding push
    for (int i = 0; i < 3; i++) begin
      push_v = 4'hF;
      for (int p = 0; p < NP; p++) d_v[p] = 31'($urandom);
      tick("pre_rst");
    end
    rst_v = 1'b1; push_v = 4'hF; tick("mid_rst");
    chk("mid_rst_in0", interface_in_0, 32'h0);
    chk("mid_rst_full", {28'h0, meta_full}, 32'h0);
    tick("post_rst");

    // random traffic: push-heavy then balanced, rare resets
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < NP; p++) begin
        push_v[p] = ($urandom_range(0, 99) < ((n < 300) ? 75 : 50));
        ack_v[p]  = ($urandom_range(0, 99) < ((n < 300) ? 30 : 50));
        d_v[p]    = 31'($urandom);
      end
      rst_v = ($urandom_range(0, 149) == 0);
      tick("rand");
`ifdef EGRESS_META_DROP_CNT_EN
      chk("rand_drop0", {16'h0, meta_drop_cnt_0}, drop_m[0]);
      chk("rand_drop3", {16'h0, meta_drop_cnt_3}, drop_m[3]);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
